// File: rtl/operand_fetch_stage.sv
// Operand fetch: register file read, writeback bypass, busy-bit
// scoreboard for RAW/WAW stalls and a one-entry output register.
module operand_fetch_stage #(
  parameter bit R0_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_sr1,
  input  logic [4:0]  in_sr2,
  input  logic [4:0]  in_dr,
  input  logic        in_wen,
  output logic [4:0]  rf_sr1,
  output logic [4:0]  rf_sr2,
  input  logic [31:0] rf_rdData1,
  input  logic [31:0] rf_rdData2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_dr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [4:0]  out_dr,
  output logic        out_wen,
  output logic        sb_err
);

  logic [31:0] busy_q, busy_d;
  logic        sb_err_q, sb_err_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_op1_q, out_op1_d;
  logic [31:0] out_op2_q, out_op2_d;
  logic [4:0]  out_dr_q, out_dr_d;
  logic        out_wen_q, out_wen_d;

  logic        sr1_zero, sr2_zero, dr_zero, wb_zero;
  logic        hit1, hit2, hit_dr;
  logic        raw, waw, accept;
  logic [31:0] op1_sel, op2_sel;
  logic [31:0] clr_vec, set_vec;

  assign rf_sr1 = in_sr1;
  assign rf_sr2 = in_sr2;

  always_comb begin
    sr1_zero = R0_ZERO && (in_sr1 == 5'd0);
    sr2_zero = R0_ZERO && (in_sr2 == 5'd0);
    dr_zero  = R0_ZERO && (in_dr == 5'd0);
    wb_zero  = R0_ZERO && (wb_dr == 5'd0);
    hit1     = wb_valid && (wb_dr == in_sr1);
    hit2     = wb_valid && (wb_dr == in_sr2);
    hit_dr   = wb_valid && (wb_dr == in_dr);
  end

  // Array read data is stale when the write lands this edge.
  always_comb begin
    op1_sel = rf_rdData1;
    if (sr1_zero)  op1_sel = 32'h0;
    else if (hit1) op1_sel = wb_data;
    op2_sel = rf_rdData2;
    if (sr2_zero)  op2_sel = 32'h0;
    else if (hit2) op2_sel = wb_data;
  end

  always_comb begin
    raw = (busy_q[in_sr1] && !hit1 && !sr1_zero)
       || (busy_q[in_sr2] && !hit2 && !sr2_zero);
    waw = in_wen && busy_q[in_dr] && !hit_dr;
    in_ready = !raw && !waw
            && (!out_valid_q || out_ready);
    accept = in_valid && in_ready;
  end

  // Set after clear so a retiring writer re-marked busy stays busy.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wb_valid)
      clr_vec = 32'h1 << wb_dr;
    if (accept && in_wen && !dr_zero)
      set_vec = 32'h1 << in_dr;
    busy_d = (busy_q & ~clr_vec) | set_vec;
    if (R0_ZERO)
      busy_d[0] = 1'b0;
  end

  always_comb begin
    sb_err_d = sb_err_q;
    if (wb_valid && !busy_q[wb_dr] && !wb_zero)
      sb_err_d = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_dr_d    = out_dr_q;
    out_wen_d   = out_wen_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_op1_d   = op1_sel;
      out_op2_d   = op2_sel;
      out_dr_d    = in_dr;
      out_wen_d   = in_wen;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      sb_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_dr_q    <= '0;
      out_wen_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      sb_err_q    <= sb_err_d;
      out_valid_q <= out_valid_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_dr_q    <= out_dr_d;
      out_wen_q   <= out_wen_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_dr    = out_dr_q;
  assign out_wen   = out_wen_q;
  assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: register file model, pending-set
// reference model checked every cycle, plus directed literal checks.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_sr1, in_sr2, in_dr;
  logic        in_wen;
  logic [4:0]  rf_sr1, rf_sr2;
  logic [31:0] rf_rdData1, rf_rdData2;
  logic        wb_valid;
  logic [4:0]  wb_dr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_dr;
  logic        out_wen, sb_err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] regs [32];

  always #5 clk = ~clk;

  operand_fetch_stage #(.R0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2),
    .in_dr(in_dr), .in_wen(in_wen),
    .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
    .rf_rdData1(rf_rdData1), .rf_rdData2(rf_rdData2),
    .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2),
    .out_dr(out_dr), .out_wen(out_wen),
    .sb_err(sb_err)
  );

  // External register file: combinational read, posedge write.
  always @(posedge clk)
    if (wb_valid) regs[wb_dr] <= wb_data;
  assign rf_rdData1 = regs[rf_sr1];
  assign rf_rdData2 = regs[rf_sr2];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: a set of pending destinations and the
  // bundle last handed downstream.
  bit          pend [32];
  bit          m_v, m_wen, m_err;
  logic [31:0] m_op1, m_op2;
  logic [4:0]  m_dr;

  function automatic bit wb_hits(input logic [4:0] r);
    return wb_valid && wb_dr == r;
  endfunction

  function automatic bit src_blocked(input logic [4:0] r);
    if (r == 0) return 1'b0;
    return pend[r] && !wb_hits(r);
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_hits(r)) return wb_data;
    return regs[r];
  endfunction

  initial begin : compare
    bit          e_rdy, acc, skip;
    bit          n_v, n_wen, n_err;
    logic [31:0] n_op1, n_op2;
    logic [4:0]  n_dr;
    bit          n_pend [32];
    forever begin
      @(negedge clk);
      if (rst) begin
        foreach (pend[i]) pend[i] = 1'b0;
        m_v = 0; m_wen = 0; m_err = 0;
        m_op1 = 0; m_op2 = 0; m_dr = 0;
      end
      e_rdy = !src_blocked(in_sr1)
           && !src_blocked(in_sr2)
           && !(in_wen && pend[in_dr] && !wb_hits(in_dr))
           && (!m_v || out_ready);
      chk("in_ready", {31'b0, in_ready}, {31'b0, e_rdy});
      chk("rf_sr1", {27'b0, rf_sr1}, {27'b0, in_sr1});
      chk("rf_sr2", {27'b0, rf_sr2}, {27'b0, in_sr2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_v});
      chk("out_op1", out_op1, m_op1);
      chk("out_op2", out_op2, m_op2);
      chk("out_dr", {27'b0, out_dr}, {27'b0, m_dr});
      chk("out_wen", {31'b0, out_wen}, {31'b0, m_wen});
      chk("sb_err", {31'b0, sb_err}, {31'b0, m_err});
      skip = rst;
      acc = in_valid && e_rdy;
      n_pend = pend;
      n_v = m_v; n_wen = m_wen; n_op1 = m_op1;
      n_op2 = m_op2; n_dr = m_dr; n_err = m_err;
      if (wb_valid) begin
        if (!pend[wb_dr] && wb_dr != 0) n_err = 1'b1;
        n_pend[wb_dr] = 1'b0;
      end
      if (acc) begin
        if (in_wen && in_dr != 0) n_pend[in_dr] = 1'b1;
        n_v = 1; n_wen = in_wen; n_dr = in_dr;
        n_op1 = src_val(in_sr1);
        n_op2 = src_val(in_sr2);
      end else if (m_v && out_ready) begin
        n_v = 0;
      end
      @(posedge clk);
      if (!skip && !rst) begin
        pend = n_pend;
        m_v = n_v; m_wen = n_wen; m_err = n_err;
        m_op1 = n_op1; m_op2 = n_op2; m_dr = n_dr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] s1,
                       input logic [4:0] s2,
                       input logic [4:0] d,
                       input logic w);
    in_valid = 1'b1;
    in_sr1 = s1; in_sr2 = s2;
    in_dr = d; in_wen = w;
  endtask

  task automatic wb(input logic [4:0] d,
                    input logic [31:0] v);
    wb_valid = 1'b1; wb_dr = d; wb_data = v;
  endtask

  initial begin : stim
    rst = 1'b1;
    in_valid = 0; in_sr1 = 0; in_sr2 = 0;
    in_dr = 0; in_wen = 0;
    wb_valid = 0; wb_dr = 0; wb_data = 0;
    out_ready = 1'b1;
    // Preload the register file through its write port.
    for (int i = 0; i < 32; i++) begin
      wb(5'(i), (i == 0) ? 32'h55 :
                (i == 1) ? 32'h11 :
                (i == 2) ? 32'h22 : 32'h1000 + i);
      step();
    end
    wb_valid = 0;
    step();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_op1", out_op1, 32'h0);
    chk("rst_err", {31'b0, sb_err}, 32'h0);
    rst = 1'b0;
    step();

    // Basic issue.
    issue(1, 2, 3, 1);
    #1 chk("t1_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("t1_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_op1", out_op1, 32'h11);
    chk("t1_op2", out_op2, 32'h22);
    chk("t1_dr", {27'b0, out_dr}, 32'd3);

    // RAW on r3, released by a bypassed writeback.
    issue(3, 2, 4, 1);
    #1 chk("raw_stall", {31'b0, in_ready}, 32'h0);
    step(); step(); step();
    wb(3, 32'hDEAD);
    #1 chk("raw_release", {31'b0, in_ready}, 32'h1);
    step();
    wb_valid = 0;
    chk("byp_op1", out_op1, 32'hDEAD);
    chk("byp_op2", out_op2, 32'h22);
    chk("byp_dr", {27'b0, out_dr}, 32'd4);

    // Backpressure holds the bundle.
    out_ready = 0;
    issue(3, 1, 6, 1);
    #1 chk("bp_ready", {31'b0, in_ready}, 32'h0);
    step();
    chk("bp_hold1", out_op1, 32'hDEAD);
    step();
    chk("bp_hold2", {27'b0, out_dr}, 32'd4);
    chk("bp_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1;
    #1 chk("bp_go", {31'b0, in_ready}, 32'h1);
    step();
    chk("bp_op1", out_op1, 32'hDEAD);
    chk("bp_op2", out_op2, 32'h11);
    chk("bp_dr", {27'b0, out_dr}, 32'd6);

    // Register zero reads 0 and is never busy.
    issue(0, 2, 0, 1);
    #1 chk("r0_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("r0_op1", out_op1, 32'h0);
    chk("r0_op2", out_op2, 32'h22);
    issue(0, 0, 8, 0);
    #1 chk("r0_nostall", {31'b0, in_ready}, 32'h1);
    step();
    chk("r0_op2b", out_op2, 32'h0);
    chk("r0_wen", {31'b0, out_wen}, 32'h0);

    // WAW on r5; set wins over same-cycle clear.
    issue(1, 2, 5, 1);
    step();
    #1 chk("waw_stall", {31'b0, in_ready}, 32'h0);
    step();
    wb(5, 32'h5555);
    #1 chk("waw_go", {31'b0, in_ready}, 32'h1);
    step();
    wb_valid = 0;
    issue(5, 1, 9, 0);
    #1 chk("setwin", {31'b0, in_ready}, 32'h0);
    step();
    wb(5, 32'h6666);
    #1 chk("r5_go", {31'b0, in_ready}, 32'h1);
    step();
    wb_valid = 0;
    in_valid = 0;
    chk("r5_op1", out_op1, 32'h6666);
    chk("no_err", {31'b0, sb_err}, 32'h0);

    // Stray writeback.
    wb(7, 32'h7777);
    step();
    wb_valid = 0;
    chk("err_set", {31'b0, sb_err}, 32'h1);
    step();
    chk("err_stick", {31'b0, sb_err}, 32'h1);

    // Reset during a RAW stall on r4.
    issue(4, 0, 10, 0);
    #1 chk("pre_rst", {31'b0, in_ready}, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_err", {31'b0, sb_err}, 32'h0);
    chk("arst_ready", {31'b0, in_ready}, 32'h1);
    step();
    rst = 1'b0;
    in_valid = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Issue-side neighbour of the team's 32x32 two-read/one-write register file.
- Accepts decoded instructions (sr1, sr2, dr) over valid/ready, drives the register file read addresses and captures the operands.
- Tracks pending destination registers in a 32-entry scoreboard and stalls on RAW/WAW hazards.
- Bypasses same-cycle writeback data, then presents operands downstream through a one-entry output register.

Parameters:
- R0_ZERO, 1, when 1 register 0 reads as 32'h0 and is never marked busy; when 0 register 0 is ordinary.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  stage accepts the instruction this cycle (combinational).
- in_sr1  input  5  source register 1.
- in_sr2  input  5  source register 2.
- in_dr  input  5  destination register.
- in_wen  input  1  instruction will write in_dr.
- rf_sr1  output  5  register file read address 1; equals in_sr1 (combinational).
- rf_sr2  output  5  register file read address 2; equals in_sr2 (combinational).
- rf_rdData1  input  32  register file read data 1 (combinational read).
- rf_rdData2  input  32  register file read data 2.
- wb_valid  input  1  writeback retiring this cycle; the same signals drive the register file write port.
- wb_dr  input  5  writeback destination.
- wb_data  input  32  writeback data.
- out_valid  output  1  operand bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- out_op1  output  32  operand 1.
- out_op2  output  32  operand 2.
- out_dr  output  5  destination register.
- out_wen  output  1  write enable carried forward.
- sb_err  output  1  sticky flag: writeback arrived for a non-busy register.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_op1=0, out_op2=0, out_dr=0, out_wen=0.
  - busy[31:0]=0, sb_err=0.
  - Reset asserted mid-stall or mid-backpressure discards the held instruction and all pending scoreboard state.
- Operand select, sourceN (N=1,2):
  - If R0_ZERO and srN==0: 0.
  - Else if wb_valid and wb_dr==srN: wb_data. The register file write lands at the same edge, so array read data is stale this cycle.
  - Else: rf_rdDataN.
- Hazard, combinational:
  - raw = for either source: busy[srN] && !(wb_valid && wb_dr==srN) && !(R0_ZERO && srN==0).
  - waw = in_wen && busy[in_dr] && !(wb_valid && wb_dr==in_dr).
- Handshake:
  - in_ready = !raw && !waw && (!out_valid || out_ready).
  - accept = in_valid && in_ready.
  - in_ready does not depend on in_valid.
- Output register:
  - On accept: out_op1/out_op2 load the selected operands, out_dr<=in_dr, out_wen<=in_wen, out_valid<=1.
  - Else if out_valid && out_ready: out_valid<=0 and the data registers hold.
  - While out_valid && !out_ready, all out_* remain stable.
  - Latency: accept at edge N means the bundle is valid after edge N. Throughput is 1 per cycle when hazard-free and out_ready=1.
- Scoreboard, per posedge:
  - clr = wb_valid ? onehot(wb_dr) : 0.
  - set = (accept && in_wen && !(R0_ZERO && in_dr==0)) ? onehot(in_dr) : 0.
  - busy <= (busy & ~clr) | set. Set wins when set and clear hit the same register.
  - If R0_ZERO, busy[0] is forced to 0.
- sb_err:
  - Set when wb_valid && !busy[wb_dr], excluding R0_ZERO && wb_dr==0.
  - Cleared only by rst.
  - The stray writeback still reaches the register file (external) and is still bypassed.
- Implementation constraints: no other state; no combinational path from out_ready to out_* data.

Test Plan:
- Preload r1=0x11, r2=0x22; issue sr1=1, sr2=2, dr=3, wen=1, out_ready=1 -> next cycle out_valid=1, op1=0x11, op2=0x22, out_dr=3; busy[3]=1.
- Following instruction sr1=3 -> in_ready=0; 3 cycles later wb_valid, wb_dr=3, wb_data=0xDEAD -> accepted that cycle, next cycle op1=0xDEAD, busy[3]=0.
- out_ready=0 for 2 cycles with out_valid=1 -> out_* unchanged and in_ready=0; out_ready=1 -> held bundle accepted, queued instruction enters next edge.
- R0_ZERO=1, r0 preloaded 0x55, sr1=0 -> op1=0; dr=0, wen=1 -> busy[0] stays 0, no stall on the next sr1=0.
- busy[5]=1, new instruction dr=5, wen=1 -> stalls; in the cycle wb_dr=5 arrives -> accepted, busy[5] remains 1 (set wins).
- wb_valid, wb_dr=7 with busy[7]=0 -> sb_err=1 and stays 1; assert rst during a RAW stall -> out_valid=0, busy=0, sb_err=0 immediately.
